seq_wide_adder: RTL and testbench
=================================

// Module: seq_wide_adder
// PURPOSE
//   Multi-cycle wide adder. One 4-bit ripple-carry slice built from full_adder
//   cells is reused over WIDTH/4 cycles to add two WIDTH-bit operands.
//   The carry between slices is held in a register.
//   Sits between an operand producer and a result consumer.
//   Both sides use valid/ready handshakes; one operation is in flight at a time.
// PARAMETERS
//   WIDTH   16   operand/sum width in bits; multiple of 4, >= 4
//   NSLICE  WIDTH/4 (localparam)   number of slice cycles per add
// PORTS
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      operands a, b, cin valid
//   in_ready   out  1      block can accept operands (state IDLE)
//   a          in   WIDTH  operand A
//   b          in   WIDTH  operand B
//   cin        in   1      carry-in to bit 0
//   out_valid  out  1      sum/cout valid (state DONE)
//   out_ready  in   1      consumer takes result
//   sum        out  WIDTH  registered result, modulo 2^WIDTH
//   cout       out  1      carry out of bit WIDTH-1
//   busy       out  1      high in RUN or DONE
// BEHAVIOUR
//   Reset (rst_n low, async): state=IDLE; sum=0; cout=0; out_valid=0; busy=0;
//     slice counter=0; carry reg=0; operand regs=0. in_ready=1 once rst_n is high.
//   FSM states: IDLE -> RUN -> DONE -> IDLE.
//   IDLE: in_ready=1. On an edge with in_valid=1, capture a, b and cin into
//     internal registers, clear the counter and go to RUN. Inputs are ignored
//     while in_valid=0.
//   RUN: in_ready=0. Each cycle k (0..NSLICE-1):
//     - add operand bits [4k+3:4k] plus the carry reg;
//     - write the 4 result bits into sum[4k+3:4k] and the slice carry-out into
//       the carry reg.
//     After slice NSLICE-1, cout takes the final carry and the state goes to DONE.
//   DONE: out_valid=1. sum and cout are held stable. On an edge with
//     out_ready=1, go to IDLE and drop out_valid; sum and cout keep their
//     values until the next slice writes.
//   Latency: out_valid rises on the NSLICE-th rising edge after the accept edge.
//     Throughput is one add per NSLICE+2 cycles with no overlap.
//   sum is only guaranteed while out_valid=1. Partial slices are visible on
//     sum during RUN.
//   Boundaries:
//     - in_valid while not IDLE: ignored; operands are not captured or queued.
//     - out_ready while not DONE: ignored.
//     - out_ready held high in DONE: handshake completes on the first DONE edge
//       (out_valid is high for exactly 1 cycle).
//     - WIDTH=4: RUN lasts 1 cycle.
//     - rst_n low mid-RUN or mid-DONE: the operation is aborted, all reset
//       values apply, and no out_valid is produced for the aborted operation.
//     - Carry reg never leaks between operations: it is loaded from cin at accept.
// TESTING (WIDTH=16 unless stated)
//   1. a=0xFFFF, b=0x0001, cin=0 -> 4 cycles later out_valid=1, sum=0x0000, cout=1.
//   2. a=0x1234, b=0x4321, cin=1 -> sum=0x5556, cout=0; in_ready=0 throughout RUN.
//   3. Hold out_ready=0 for 5 cycles in DONE while driving in_valid with new
//      operands -> sum/cout stable, in_ready=0, new operands not captured.
//      Then out_ready=1 -> IDLE.
//   4. Pulse rst_n low during RUN slice 2 -> all outputs 0 immediately.
//      Next add 0x00FF+0x0001 -> sum=0x0100, cout=0.
//   5. Back-to-back with out_ready tied to 1: 0x8000+0x8000 then 0x0F0F+0xF0F0
//      with cin=1 -> (0x0000, cout 1) then (0x0000, cout 1); each out_valid
//      lasts 1 cycle.
//   6. WIDTH=4: a=0x9, b=0x8, cin=1 -> out_valid 1 cycle after accept,
//      sum=0x2, cout=1.
//   Plus a random self-check of {cout,sum} == a+b+cin over 1000 operations
//   with random handshake stalls.

Source files
------------

// File: rtl/seq_wide_adder.sv
// rtl/seq_wide_adder.sv - multi-cycle wide adder reusing one 4-bit ripple slice
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module seq_wide_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);
    localparam int NSLICE = WIDTH / 4;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic [3:0] slice_a;
    logic [3:0] slice_b;
    logic [3:0] slice_s;
    logic [4:0] chain;
    logic       last_slice;

    // Select the operand nibbles addressed by the slice counter.
    always_comb begin
        slice_a = '0;
        slice_b = '0;
        for (int k = 0; k < NSLICE; k++) begin
            if (cnt == CW'(k)) begin
                slice_a = a_q[4*k +: 4];
                slice_b = b_q[4*k +: 4];
            end
        end
    end

    assign chain[0] = carry;

    genvar i;
    generate
        for (i = 0; i < 4; i++) begin : g_fa
            full_adder u_fa (
                .a  (slice_a[i]),
                .b  (slice_b[i]),
                .ci (chain[i]),
                .s  (slice_s[i]),
                .co (chain[i+1])
            );
        end
    endgenerate

    assign last_slice = (cnt == CW'(NSLICE - 1));

    // Control FSM; also owns the operand, carry, sum and handshake registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            carry     <= 1'b0;
            cnt       <= '0;
            sum       <= '0;
            cout      <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q      <= a;
                        b_q      <= b;
                        carry    <= cin;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    for (int k = 0; k < NSLICE; k++) begin
                        if (cnt == CW'(k)) begin
                            sum[4*k +: 4] <= slice_s;
                        end
                    end
                    carry <= chain[4];
                    if (last_slice) begin
                        cout      <= chain[4];
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_seq_wide_adder.sv
// tb/tb_seq_wide_adder.sv - scoreboard bench for seq_wide_adder
module tb_seq_wide_adder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        cin = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] sum;
    logic        cout;
    logic        busy;

    logic        in_valid4 = 1'b0;
    logic        in_ready4;
    logic [3:0]  a4 = '0;
    logic [3:0]  b4 = '0;
    logic        cin4 = 1'b0;
    logic        out_valid4;
    logic        out_ready4 = 1'b1;
    logic [3:0]  sum4;
    logic        cout4;
    logic        busy4;

    int          checks = 0;
    int          errors = 0;
    logic [16:0] sb[$];
    bit          rmode = 1'b0;
    bit          held = 1'b0;
    logic [16:0] held_val;
    bit          took = 1'b0;

    seq_wide_adder #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .busy(busy)
    );

    seq_wide_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .cin(cin4), .out_valid(out_valid4), .out_ready(out_ready4),
        .sum(sum4), .cout(cout4), .busy(busy4)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every completed output handshake.
    always @(negedge clk) begin
        if (!rst_n) begin
            held = 1'b0;
            took = 1'b0;
        end else begin
            if (took) chk("out_valid_one_cycle", 32'(out_valid), 32'd0);
            took = 1'b0;
            if (out_valid) begin
                if (held) chk("done_hold_stable", 32'({cout, sum}), 32'(held_val));
                if (out_ready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_result: got 0x%0h with empty scoreboard", {cout, sum});
                    end else begin
                        chk("result", 32'({cout, sum}), 32'(sb.pop_front()));
                    end
                    held = 1'b0;
                    took = 1'b1;
                end else begin
                    held = 1'b1;
                    held_val = {cout, sum};
                end
            end else begin
                held = 1'b0;
            end
        end
    end

    // Random consumer stalls when enabled.
    always @(posedge clk) begin
        if (rmode) begin
            #1 out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Issue one operation; entered and left 1 time unit after a rising edge.
    task automatic do_add(input logic [15:0] x, input logic [15:0] y, input logic c, input int gap);
        bit done;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        a = x;
        b = y;
        cin = c;
        in_valid = 1'b1;
        done = 1'b0;
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back({1'b0, x} + {1'b0, y} + {16'd0, c});
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got in_ready 0 expected 1");
        end
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 50) begin
            chk("in_ready_low_in_run", 32'(in_ready), 32'd0);
            chk("busy_high_in_run", 32'(busy), 32'd1);
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((sb.size() != 0 || busy) && t < 2000) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("drain", 32'(sb.size() != 0 || busy), 32'd0);
    endtask

    initial begin
        int lat;
        #1;
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // 1: carry ripples through every slice; latency NSLICE
        out_ready = 1'b1;
        do_add(16'hFFFF, 16'h0001, 1'b0, 0);
        wait_valid(lat);
        chk("latency", 32'(lat), 32'd4);
        drain();

        // 2
        do_add(16'h1234, 16'h4321, 1'b1, 0);
        wait_valid(lat);
        drain();

        // 3: stall in DONE while new operands are offered
        out_ready = 1'b0;
        do_add(16'hAAAA, 16'h5555, 1'b1, 0);
        wait_valid(lat);
        a = 16'h1234;
        b = 16'h0001;
        cin = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            chk("stall_out_valid", 32'(out_valid), 32'd1);
            chk("stall_sum", 32'({cout, sum}), 32'h10000);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("release_in_ready", 32'(in_ready), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("no_capture_busy", 32'(busy), 32'd0);
        chk("no_capture_sb", 32'(sb.size()), 32'd0);

        // 4: reset mid-RUN at slice 2
        do_add(16'h1111, 16'h2222, 1'b0, 0);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_sum", 32'(sum), 32'd0);
        chk("abort_cout", 32'(cout), 32'd0);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        void'(sb.pop_back());
        @(posedge clk);
        #1 rst_n = 1'b1;
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        do_add(16'h00FF, 16'h0001, 1'b0, 0);
        drain();

        // 5: back-to-back with out_ready tied high
        do_add(16'h8000, 16'h8000, 1'b0, 0);
        do_add(16'h0F0F, 16'hF0F0, 1'b1, 0);
        drain();

        // 6: WIDTH=4 instance
        a4 = 4'h9;
        b4 = 4'h8;
        cin4 = 1'b1;
        in_valid4 = 1'b1;
        chk("w4_in_ready", 32'(in_ready4), 32'd1);
        @(posedge clk);
        #1 in_valid4 = 1'b0;
        chk("w4_run_no_valid", 32'(out_valid4), 32'd0);
        @(posedge clk);
        #1;
        chk("w4_out_valid", 32'(out_valid4), 32'd1);
        chk("w4_result", 32'({cout4, sum4}), 32'h12);
        @(posedge clk);
        #1;
        chk("w4_out_valid_drop", 32'(out_valid4), 32'd0);

        // random operations with random producer gaps and consumer stalls
        rmode = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            do_add(16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
        end
        drain();
        rmode = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
